ro_freq_scanner: RTL

Parametrised multi-channel successor to the single-channel ring-oscillator thermometer path. It synchronises `NUM_CH` asynchronous ring-oscillator outputs and counts rising edges of all channels over a shared fixed window. At each window end it snapshots the counts and emits one framed, checksummed byte packet through a valid/ready byte stream. A downstream UART transmitter consumes that stream.

---
 rtl/ro_freq_scanner.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/ro_freq_scanner.sv
// Multi-channel ring-oscillator edge counter. Counts synchronised rising edges per channel over a
// fixed window and streams a framed, checksummed snapshot of the counts as a byte stream.
module ro_freq_scanner #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WIN_CYCLES  = 50000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] ro_in,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);

  localparam int unsigned NB    = CNT_W / 8;
  localparam int unsigned WIN_W = $clog2(WIN_CYCLES);

  typedef enum logic [2:0] {
    StIdle, StHdr, StSeq, StSat, StChId, StChByte, StCsum
  } state_e;

  logic clr;
  assign clr = rst | ~en;

  // Synchronisers and rising-edge detection
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] rise;

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= ro_in;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Saturating edge counters and window timer
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] sat_q, sat_nxt;
  logic [WIN_W-1:0]  win_cnt_q;
  logic              win_end;

  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cnt_nxt[i] = cnt_q[i];
      sat_nxt[i] = sat_q[i];
      if (rise[i]) begin
        if (&cnt_q[i]) sat_nxt[i] = 1'b1;
        else           cnt_nxt[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign win_end = (win_cnt_q == WIN_W'(WIN_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (clr || win_end) begin
      for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= '0;
      sat_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= cnt_nxt[i];
      sat_q <= sat_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (clr || win_end) win_cnt_q <= '0;
    else                win_cnt_q <= win_cnt_q + 1'b1;
  end

  // Frame sequencer
  state_e                   state_q;
  logic [7:0]               tx_data_q;
  logic                     tx_valid_q, busy_q;
  logic [6:0]               seq_q;
  logic                     overrun_q, late_drop_q;
  logic [7:0]               csum_q;
  logic [3:0]               ch_q;
  logic [2:0]               byte_idx_q;
  logic [NUM_CH*CNT_W-1:0]  snap_cnt_q;
  logic [NUM_CH-1:0]        snap_sat_q, snap_mask_q;
  logic                     snap_ovr_q;

  logic       acc, last_byte, nxt_found;
  logic [3:0] srch_start, nxt_ch;
  logic [2:0] bsel;
  logic [31:0] shamt;
  logic [7:0] cnt_byte, csum_add;

  assign acc       = tx_valid_q & tx_ready;
  assign last_byte = (byte_idx_q == 3'(NB - 1));
  assign csum_add  = csum_q + tx_data_q;

  // Lowest masked channel at or above srch_start
  always_comb begin
    srch_start = (state_q == StSat) ? 4'd0 : ch_q + 4'd1;
    nxt_found  = 1'b0;
    nxt_ch     = 4'd0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (snap_mask_q[i] && (4'(i) >= srch_start)) begin
        nxt_found = 1'b1;
        nxt_ch    = 4'(i);
      end
    end
  end

  always_comb begin
    bsel     = (state_q == StChId) ? 3'd0 : byte_idx_q + 3'd1;
    shamt    = 32'(ch_q) * CNT_W + 8 * (NB - 1 - 32'(bsel));
    cnt_byte = 8'(snap_cnt_q >> shamt);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      seq_q       <= '0;
      overrun_q   <= 1'b0;
      late_drop_q <= 1'b0;
      csum_q      <= 8'h00;
      ch_q        <= 4'd0;
      byte_idx_q  <= 3'd0;
      snap_cnt_q  <= '0;
      snap_sat_q  <= '0;
      snap_mask_q <= '0;
      snap_ovr_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: if (win_end) begin
          for (int i = 0; i < int'(NUM_CH); i++) snap_cnt_q[i*CNT_W +: CNT_W] <= cnt_nxt[i];
          snap_sat_q  <= sat_nxt;
          snap_mask_q <= ch_mask;
          snap_ovr_q  <= overrun_q;
          late_drop_q <= 1'b0;
          csum_q      <= 8'h00;
          tx_data_q   <= 8'hA5;
          tx_valid_q  <= 1'b1;
          busy_q      <= 1'b1;
          state_q     <= StHdr;
        end
        StHdr: if (acc) begin
          csum_q    <= csum_add;
          tx_data_q <= {snap_ovr_q, seq_q};
          state_q   <= StSeq;
        end
        StSeq: if (acc) begin
          csum_q    <= csum_add;
          tx_data_q <= 8'(snap_sat_q);
          // Drops after this frame's snapshot belong to the next frame
          overrun_q <= late_drop_q;
          state_q   <= StSat;
        end
        StSat, StChByte: if (acc) begin
          csum_q <= csum_add;
          if (state_q == StChByte && !last_byte) begin
            byte_idx_q <= byte_idx_q + 3'd1;
            tx_data_q  <= cnt_byte;
          end else if (nxt_found) begin
            ch_q      <= nxt_ch;
            tx_data_q <= {4'd0, nxt_ch};
            state_q   <= StChId;
          end else begin
            tx_data_q <= csum_add;
            state_q   <= StCsum;
          end
        end
        StChId: if (acc) begin
          csum_q     <= csum_add;
          byte_idx_q <= 3'd0;
          tx_data_q  <= cnt_byte;
          state_q    <= StChByte;
        end
        StCsum: if (acc) begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          seq_q      <= seq_q + 7'd1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if (win_end && busy_q) begin
        overrun_q   <= 1'b1;
        late_drop_q <= 1'b1;
      end
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;

endmodule
